// File: rtl/nts_rx_buffer_arbiter.sv
// rtl/nts_rx_buffer_arbiter.sv - two-requester round-robin arbiter for the nts_rx_buffer read port
//
// Purpose:
//   Serialises reads from the header parser (requester 0) and the
//   crypto/extension engine (requester 1) onto the single buffer access
//   port. Sequences the rd_en / wait / rd_dv handshake, routes the returned
//   word to the granted requester, and aborts reads the buffer never
//   completes with an error response.
//
// Ports:
//   i_clk, i_areset_n          clock, asynchronous active-low reset
//   i_clear                    synchronous flush; drops any in-flight read
//   i_reqN/i_addrN/i_wordsizeN requester N level request, byte address, size code
//   o_dvN/o_errN               requester N one-cycle response pulse, timeout flag
//   o_rd_data                  shared response data, valid with o_dv0/o_dv1
//   o_busy                     high whenever the arbiter is not idle
//   i_access_port_wait         buffer busy; no new grant while high
//   o_access_port_addr/_wordsize/_rd_en   read command to the buffer
//   i_access_port_rd_dv/_rd_data          read response from the buffer

module nts_rx_buffer_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_clear,

  input  logic                  i_req0,
  input  logic [ADDR_WIDTH+2:0] i_addr0,
  input  logic [2:0]            i_wordsize0,
  output logic                  o_dv0,
  output logic                  o_err0,

  input  logic                  i_req1,
  input  logic [ADDR_WIDTH+2:0] i_addr1,
  input  logic [2:0]            i_wordsize1,
  output logic                  o_dv1,
  output logic                  o_err1,

  output logic [63:0]           o_rd_data,
  output logic                  o_busy,

  input  logic                  i_access_port_wait,
  output logic [ADDR_WIDTH+2:0] o_access_port_addr,
  output logic [2:0]            o_access_port_wordsize,
  output logic                  o_access_port_rd_en,
  input  logic                  i_access_port_rd_dv,
  input  logic [63:0]           i_access_port_rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH+2:0] addr_q, addr_d;
  logic [2:0]            wordsize_q, wordsize_d;
  logic                  rd_en_q, rd_en_d;
  logic                  dv0_q, dv0_d;
  logic                  dv1_q, dv1_d;
  logic                  err0_q, err0_d;
  logic                  err1_q, err1_d;
  logic [63:0]           rd_data_q, rd_data_d;
  logic                  busy_q, busy_d;
  logic                  pick;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wordsize_d   = wordsize_q;
    rd_data_d    = rd_data_q;
    rd_en_d      = 1'b0;
    dv0_d        = 1'b0;
    dv1_d        = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    pick         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!i_access_port_wait && (i_req0 || i_req1)) begin
          // On contention the requester that was not served last wins.
          if (i_req0 && i_req1) begin
            pick = ~last_grant_q;
          end else begin
            pick = i_req1;
          end
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = pick ? i_addr1 : i_addr0;
          wordsize_d   = pick ? i_wordsize1 : i_wordsize0;
          rd_en_d      = 1'b1;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (i_access_port_rd_dv) begin
          rd_data_d = i_access_port_rd_data;
          dv0_d     = ~grant_q;
          dv1_d     = grant_q;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rd_data_d = '0;
          dv0_d     = ~grant_q;
          dv1_d     = grant_q;
          err0_d    = ~grant_q;
          err1_d    = grant_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush drops the in-flight read silently; the last address and data stay visible.
    if (i_clear) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      last_grant_d = 1'b1;
      grant_d      = grant_q;
      addr_d       = addr_q;
      wordsize_d   = wordsize_q;
      rd_data_d    = rd_data_q;
      rd_en_d      = 1'b0;
      dv0_d        = 1'b0;
      dv1_d        = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wordsize_q   <= '0;
      rd_en_q      <= 1'b0;
      dv0_q        <= 1'b0;
      dv1_q        <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wordsize_q   <= wordsize_d;
      rd_en_q      <= rd_en_d;
      dv0_q        <= dv0_d;
      dv1_q        <= dv1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
    end
  end

  assign o_dv0                  = dv0_q;
  assign o_err0                 = err0_q;
  assign o_dv1                  = dv1_q;
  assign o_err1                 = err1_q;
  assign o_rd_data              = rd_data_q;
  assign o_busy                 = busy_q;
  assign o_access_port_addr     = addr_q;
  assign o_access_port_wordsize = wordsize_q;
  assign o_access_port_rd_en    = rd_en_q;

endmodule

// File: tb/tb_nts_rx_buffer_arbiter.sv
// tb/tb_nts_rx_buffer_arbiter.sv - directed self-checking bench for nts_rx_buffer_arbiter

module tb_nts_rx_buffer_arbiter;

  localparam int AW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          areset_n;
  logic          clear;
  logic          req0, req1;
  logic [AW+2:0] addr0, addr1;
  logic [2:0]    ws0, ws1;
  logic          dv0, dv1, err0, err1;
  logic [63:0]   rd_data;
  logic          busy;
  logic          ap_wait;
  logic [AW+2:0] ap_addr;
  logic [2:0]    ap_ws;
  logic          ap_rd_en;
  logic          ap_rd_dv;
  logic [63:0]   ap_rd_data;

  int checks = 0;
  int errors = 0;

  int            stub_latency = 1;
  logic          stub_mute = 1'b0;
  int            stub_cnt = 0;
  logic [AW+2:0] stub_addr;
  logic [2:0]    stub_ws;

  nts_rx_buffer_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clk                  (clk),
    .i_areset_n             (areset_n),
    .i_clear                (clear),
    .i_req0                 (req0),
    .i_addr0                (addr0),
    .i_wordsize0            (ws0),
    .o_dv0                  (dv0),
    .o_err0                 (err0),
    .i_req1                 (req1),
    .i_addr1                (addr1),
    .i_wordsize1            (ws1),
    .o_dv1                  (dv1),
    .o_err1                 (err1),
    .o_rd_data              (rd_data),
    .o_busy                 (busy),
    .i_access_port_wait     (ap_wait),
    .o_access_port_addr     (ap_addr),
    .o_access_port_wordsize (ap_ws),
    .o_access_port_rd_en    (ap_rd_en),
    .i_access_port_rd_dv    (ap_rd_dv),
    .i_access_port_rd_data  (ap_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [7:0] w);
    case (w)
      8'd0:    return 64'hdeadbeef00000000;
      8'd1:    return 64'habad1deac0fef00d;
      8'd2:    return 64'h0123456789abcdef;
      default: return 64'h0;
    endcase
  endfunction

  // Big-endian byte extraction, right-aligned, possibly spanning two words.
  function automatic logic [63:0] stub_read(input logic [AW+2:0] a, input logic [2:0] ws);
    logic [127:0] cat;
    logic [7:0]   w;
    logic [63:0]  top;
    int           nb;
    w   = a[AW+2:3];
    cat = {mem_word(w), mem_word(8'(w + 8'd1))};
    cat = cat << (int'(a[2:0]) * 8);
    top = cat[127:64];
    nb  = 1 << ws;
    if (nb >= 8) return top;
    return top >> (64 - 8 * nb);
  endfunction

  // Buffer stub: rd_dv arrives stub_latency cycles after the rd_en cycle.
  always @(negedge clk) begin
    ap_rd_dv   = 1'b0;
    ap_rd_data = 64'hbad0bad0bad0bad0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        ap_rd_dv   = 1'b1;
        ap_rd_data = stub_read(stub_addr, stub_ws);
      end
    end
    if (ap_rd_en && !stub_mute) begin
      stub_cnt  = stub_latency;
      stub_addr = ap_addr;
      stub_ws   = ap_ws;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    areset_n = 1'b0;
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  // Advances until a response pulse; n = negedges elapsed, -1 if the budget expires.
  task automatic wait_dv(input int budget, output int n, output int en,
                         output logic g0, output logic g1, output int both);
    n = -1; en = 0; g0 = 1'b0; g1 = 1'b0; both = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (ap_rd_en) en++;
      if (dv0 && dv1) both++;
      if (dv0 || dv1) begin
        n = i; g0 = dv0; g1 = dv1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0; clear = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; ws0 = '0; ws1 = '0; ap_wait = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({dv0, dv1, err0, err1, ap_rd_en} !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b exp 00000", {dv0, dv1, err0, err1, ap_rd_en}); end
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if ({ap_addr, ap_ws} !== 14'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", {ap_addr, ap_ws}); end
    areset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_read();
    stub_latency = 1;
    addr0 = 11'h008; ws0 = 3'd3; req0 = 1'b1;
    @(negedge clk);
    checks++; if (ap_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en got %b exp 1", ap_rd_en); end
    checks++; if (ap_addr !== 11'h008 || ap_ws !== 3'd3) begin errors++; $display("FAIL single_cmd got %h/%0d exp 008/3", ap_addr, ap_ws); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    @(negedge clk);
    checks++; if (ap_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en_pulse got %b exp 0", ap_rd_en); end
    @(negedge clk);
    checks++; if (dv0 !== 1'b1 || dv1 !== 1'b0) begin errors++; $display("FAIL single_dv got %b%b exp 10", dv0, dv1); end
    checks++; if (rd_data !== 64'habad1deac0fef00d) begin errors++; $display("FAIL single_data got %h exp abad1deac0fef00d", rd_data); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err0); end
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (dv0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_dv_pulse got dv %b busy %b exp 0 0", dv0, busy); end
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_data [4];
    int n, en, both;
    logic g0, g1;
    exp_data = '{64'hadbeef00000000ab, 64'h00000000000000ef,
                 64'hadbeef00000000ab, 64'h00000000000000ef};
    do_reset();
    stub_latency = 1;
    addr0 = 11'h001; ws0 = 3'd3;
    addr1 = 11'h017; ws1 = 3'd0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_dv(20, n, en, g0, g1, both);
      checks++; if (n !== ((i == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_latency[%0d] got %0d exp %0d", i, n, (i == 0) ? 3 : 4); end
      checks++; if ({g0, g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, {g0, g1}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (rd_data !== exp_data[i]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, rd_data, exp_data[i]); end
      checks++; if (en !== 1 || both !== 0) begin errors++; $display("FAIL rr_strobes[%0d] got rd_en %0d overlap %0d exp 1 0", i, en, both); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_stall();
    int en_cnt, busy_cnt, n, en, both;
    logic g0, g1;
    en_cnt = 0; busy_cnt = 0;
    ap_wait = 1'b1;
    addr1 = 11'h00e; ws1 = 3'd2; req1 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ap_rd_en) en_cnt++;
      if (busy) busy_cnt++;
    end
    checks++; if (en_cnt !== 0 || busy_cnt !== 0) begin errors++; $display("FAIL stall_no_issue got rd_en %0d busy %0d exp 0 0", en_cnt, busy_cnt); end
    ap_wait = 1'b0;
    @(negedge clk);
    checks++; if (ap_rd_en !== 1'b1) begin errors++; $display("FAIL stall_issue got %b exp 1", ap_rd_en); end
    wait_dv(10, n, en, g0, g1, both);
    checks++; if ({g0, g1} !== 2'b01 || n !== 2) begin errors++; $display("FAIL stall_dv got %b n %0d exp 01 n 2", {g0, g1}, n); end
    checks++; if (rd_data !== 64'h00000000f00d0123 || err1 !== 1'b0) begin errors++; $display("FAIL stall_data got %h err %b exp 00000000f00d0123 0", rd_data, err1); end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, en, both;
    logic g0, g1;
    stub_mute = 1'b1;
    addr0 = 11'h000; ws0 = 3'd3; req0 = 1'b1;
    wait_dv(100, n, en, g0, g1, both);
    checks++; if (n !== 66 || {g0, g1} !== 2'b10) begin errors++; $display("FAIL timeout_latency got n %0d grant %b exp n 66 grant 10", n, {g0, g1}); end
    checks++; if (err0 !== 1'b1 || err1 !== 1'b0) begin errors++; $display("FAIL timeout_err got %b%b exp 10", err0, err1); end
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL timeout_data got %h exp 0", rd_data); end
    req0 = 1'b0; stub_mute = 1'b0; stub_latency = 1;
    @(negedge clk);
    addr0 = 11'h010; ws0 = 3'd3; req0 = 1'b1;
    wait_dv(20, n, en, g0, g1, both);
    checks++; if (n !== 3 || g0 !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL after_timeout got n %0d dv0 %b err %b exp 3 1 0", n, g0, err0); end
    checks++; if (rd_data !== 64'h0123456789abcdef) begin errors++; $display("FAIL after_timeout_data got %h exp 0123456789abcdef", rd_data); end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int dv_cnt, n, en, both;
    logic g0, g1;
    stub_latency = 6;
    addr1 = 11'h000; ws1 = 3'd3; req1 = 1'b1;
    @(negedge clk);
    checks++; if (ap_rd_en !== 1'b1) begin errors++; $display("FAIL clear_issue got %b exp 1", ap_rd_en); end
    repeat (2) @(negedge clk);
    clear = 1'b1; req1 = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dv0 !== 1'b0 || dv1 !== 1'b0) begin errors++; $display("FAIL clear_idle got busy %b dv %b%b exp 0 00", busy, dv0, dv1); end
    checks++; if (rd_data !== 64'h0123456789abcdef || ap_addr !== 11'h000) begin errors++; $display("FAIL clear_hold got %h/%h exp 0123456789abcdef/000", rd_data, ap_addr); end
    clear = 1'b0;
    dv_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (dv0 || dv1 || busy) dv_cnt++;
    end
    checks++; if (dv_cnt !== 0 || rd_data !== 64'h0123456789abcdef) begin errors++; $display("FAIL clear_late_dv got activity %0d data %h exp 0 0123456789abcdef", dv_cnt, rd_data); end
    stub_latency = 1;
    addr0 = 11'h008; ws0 = 3'd3; req0 = 1'b1;
    wait_dv(20, n, en, g0, g1, both);
    checks++; if (n !== 3 || g0 !== 1'b1 || rd_data !== 64'habad1deac0fef00d) begin errors++; $display("FAIL after_clear got n %0d dv0 %b data %h exp 3 1 abad1deac0fef00d", n, g0, rd_data); end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, en, both;
    logic g0, g1;
    stub_latency = 6;
    addr0 = 11'h010; ws0 = 3'd3; req0 = 1'b1;
    @(negedge clk);
    checks++; if (ap_rd_en !== 1'b1) begin errors++; $display("FAIL rst_mid_issue got %b exp 1", ap_rd_en); end
    repeat (2) @(negedge clk);
    areset_n = 1'b0; req0 = 1'b0;
    #1;
    checks++; if ({busy, ap_rd_en, dv0, dv1, err0, err1} !== 6'b0) begin errors++; $display("FAIL rst_mid_ctrl got %b exp 000000", {busy, ap_rd_en, dv0, dv1, err0, err1}); end
    checks++; if (rd_data !== 64'h0 || ap_addr !== '0 || ap_ws !== '0) begin errors++; $display("FAIL rst_mid_data got %h/%h/%0d exp 0/0/0", rd_data, ap_addr, ap_ws); end
    @(negedge clk);
    areset_n = 1'b1;
    repeat (8) @(negedge clk);
    stub_latency = 1;
    addr0 = 11'h000; ws0 = 3'd1; req0 = 1'b1;
    wait_dv(20, n, en, g0, g1, both);
    checks++; if (n !== 3 || g0 !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL after_rst got n %0d dv0 %b err %b exp 3 1 0", n, g0, err0); end
    checks++; if (rd_data !== 64'h000000000000dead) begin errors++; $display("FAIL after_rst_data got %h exp 000000000000dead", rd_data); end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_stall();
    test_timeout();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/nts_rx_buffer_arbiter.md
Name: nts_rx_buffer_arbiter

Overview:
Two-requester round-robin arbiter in front of the nts_rx_buffer access port. Lets the header parser (requester 0) and the crypto/extension engine (requester 1) share the single read port: it serialises their reads, sequences the one-cycle rd_en / wait / rd_dv handshake, and routes returned data to the granted requester. A watchdog aborts reads the buffer never completes.

Parameters:
ADDR_WIDTH, 8, buffer word-address width; byte address width is ADDR_WIDTH+3
TIMEOUT, 64, max cycles in WAIT before a read is aborted with error (>=2)

Ports:
i_clk  in  1  clock
i_areset_n  in  1  asynchronous reset, active low
i_clear  in  1  synchronous abort/flush, active high
i_req0  in  1  requester 0 read request, level, held until o_dv0
i_addr0  in  ADDR_WIDTH+3  requester 0 byte address
i_wordsize0  in  3  requester 0 size code (0=8b,1=16b,2=32b,3=64b)
o_dv0  out  1  requester 0 response pulse
o_err0  out  1  requester 0 timeout flag, valid with o_dv0
i_req1, i_addr1, i_wordsize1, o_dv1, o_err1  as above for requester 1
o_rd_data  out  64  shared response data, valid with o_dv0/o_dv1
o_busy  out  1  high in any state but IDLE
i_access_port_wait  in  1  buffer busy
o_access_port_addr  out  ADDR_WIDTH+3  address to buffer
o_access_port_wordsize  out  3  size code to buffer
o_access_port_rd_en  out  1  read strobe to buffer, one cycle
i_access_port_rd_dv  in  1  buffer data valid
i_access_port_rd_data  in  64  buffer data

Behaviour:
- All outputs registered. Reset (async, i_areset_n=0): every output 0, state IDLE, timeout counter 0, last_grant=1 (requester 0 wins first contention).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if i_access_port_wait=0 and any req: grant. Only one req -> that one. Both -> requester != last_grant. Latch addr/wordsize into o_access_port_addr/_wordsize, update last_grant, -> ISSUE. If wait=1, stay IDLE; no grant.
- ISSUE: o_access_port_rd_en=1 for exactly this cycle; counter cleared; -> WAIT. Addr/wordsize held stable ISSUE through RESP.
- WAIT: rd_en=0; counter increments each cycle. On i_access_port_rd_dv=1: capture rd_data into o_rd_data, -> RESP, err=0. If counter reaches TIMEOUT-1 without rd_dv: o_rd_data=0, err=1, -> RESP. rd_dv and timeout in same cycle: rd_dv wins, err=0.
- RESP: o_dvN=1 and o_errN for granted N, exactly one cycle; -> IDLE. o_dv0 and o_dv1 never high together.
- Requester protocol: req held with stable addr/wordsize until it samples o_dvN=1; it drops req on that edge. IDLE re-samples the following cycle, so held-high req there is a new request.
- Changing addr while req high and not yet granted: allowed; value latched at grant. After grant, changes ignored.
- Latency (buffer with wait low): req high in IDLE at edge k -> rd_en cycle k+1 -> o_dv = cycle after rd_dv.
- o_rd_data holds last captured value between responses.
- rd_dv outside WAIT ignored.
- i_clear=1 (priority over all transitions): state IDLE, rd_en/dv/err 0, counter 0, last_grant=1; in-flight read dropped with no o_dv; o_rd_data and o_access_port_addr unchanged. Requests re-arbitrated after i_clear drops.
- Reset mid-read: same as clear, asynchronously; all outputs 0.
- Counter width $clog2(TIMEOUT)+1; no wrap.

Test Plan:
- Buffer preloaded deadbeef00000000, abad1deac0fef00d, 0123456789abcdef. req0 addr 'b01_000 ws3 -> single rd_en pulse, o_dv0 one cycle, o_rd_data=abad1deac0fef00d, o_err0=0, o_dv1 stays 0.
- req0 and req1 raised in same cycle after reset (req0 'b00_001 ws3, req1 'b10_111 ws0) -> req0 served first (adbeef00000000ab), then req1 (00000000000000ef); both held continuously for 4 reads -> grants alternate 0,1,0,1.
- i_access_port_wait forced high 20 cycles with req1 pending -> no rd_en while wait high; rd_en issued cycle after wait drops; o_dv1 with data f00d0123 for 'b01_110 ws2.
- Buffer stub never asserts rd_dv, TIMEOUT=64 -> o_dv0=1, o_err0=1, o_rd_data=0 exactly 64 cycles after entering WAIT; next request then completes normally.
- i_clear pulsed in WAIT -> no o_dv0/o_dv1, o_busy=0 next cycle; late rd_dv from buffer ignored; next req reads correct data.
- i_areset_n low for one cycle mid-WAIT -> all outputs 0 immediately; after release, req0 'b00_000 ws1 returns 000000000000dead.
